// File: rtl/ch_fe_pkg.sv
// ch_fe_pkg: shared sizes for the channel event frontend (channel count, index width, filter length, filter counter width)
package ch_fe_pkg;
  localparam int NCH = 4;
  localparam int CH_IDX_W = $clog2(NCH);
  localparam int FILT_LEN = 4;
  localparam int FILT_CNT_W = $clog2(FILT_LEN + 1);
endpackage

// File: rtl/ch_fe_cond.sv
// ch_fe_cond: 1-bit 2-FF sync, optional FILT_LEN glitch filter (FILT_EN), rising-edge pulse; ports clk, rst_n, din, rise
module ch_fe_cond
  import ch_fe_pkg::*;
#(
  parameter bit FILT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1, s2, lvl, prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {din, s1, lvl};
  generate
    if (FILT_EN) begin : g_filt
      logic [FILT_CNT_W-1:0] cnt;
      logic filt;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          cnt <= '0;
          filt <= 1'b0;
        end else if (s2 == filt) cnt <= '0;
        else if (cnt == FILT_CNT_W'(FILT_LEN - 1)) begin
          filt <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      assign lvl = filt;
    end else begin : g_raw
      assign lvl = s2;
    end
  endgenerate
  assign rise = lvl & ~prev;
endmodule

// File: rtl/ch_event_frontend.sv
// ch_event_frontend: per-channel sync/filter(CH_GLITCH_FILTER_EN)/edge into pending, RR valid/ready event port (evt_valid/evt_ready/evt_ch), rtc_tick, sticky ovf_ch/ovf_any with ovf_clr
module ch_event_frontend
  import ch_fe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      ch_in,
  input  logic                rtc_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_IDX_W-1:0] evt_ch,
  output logic                rtc_tick,
  output logic [NCH-1:0]      ovf_ch,
  output logic                ovf_any,
  input  logic                ovf_clr
);
`ifdef CH_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  logic [NCH-1:0] rise, pending, clr;
  logic rtc_rise, hs, lock;
  logic [CH_IDX_W-1:0] ptr, lk_ch, rr, grant, idx;
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      ch_fe_cond #(.FILT_EN(FILT_EN)) u_cond (.clk(clk), .rst_n(rst_n), .din(ch_in[i]), .rise(rise[i]));
    end
  endgenerate
  ch_fe_cond #(.FILT_EN(1'b0)) u_rtc (.clk(clk), .rst_n(rst_n), .din(rtc_in), .rise(rtc_rise));
  always_comb begin
    rr = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CH_IDX_W'((int'(ptr) + k) % NCH);
      if (pending[idx]) rr = idx;
    end
  end
  assign evt_valid = |pending;
  assign grant = lock ? lk_ch : rr;
  assign evt_ch = evt_valid ? grant : '0;
  assign hs = evt_valid & evt_ready;
  assign clr = hs ? NCH'(1) << grant : '0;
  assign ovf_any = |ovf_ch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      ovf_ch <= '0;
      lock <= 1'b0;
      lk_ch <= '0;
      ptr <= '0;
      rtc_tick <= 1'b0;
    end else begin
      pending <= rise | (pending & ~clr);
      ovf_ch <= (rise & pending & ~clr) | (ovf_ch & {NCH{~ovf_clr}});
      lock <= evt_valid & ~evt_ready;
      lk_ch <= grant;
      rtc_tick <= rtc_rise;
      if (hs) ptr <= (grant == CH_IDX_W'(NCH - 1)) ? '0 : grant + 1'b1;
    end
endmodule
